// File: rtl/vic20_pkg.sv
// vic20_pkg: shared types and constants for the VIC-20 PRG transfer logic.
// Contents: prg_up_state_t (upload FSM states), BASIC start/end pointer addresses.
package vic20_pkg;

    typedef enum logic [3:0] {
        IDLE, RD_SL, RD_SH, RD_EL, RD_EH, CHECK, HDR_L, HDR_H, FETCH, SEND, FIN
    } prg_up_state_t;

    localparam logic [15:0] BASIC_PTR_START = 16'h002B;
    localparam logic [15:0] BASIC_PTR_END   = 16'h002D;

endpackage

// File: rtl/prg_upload.sv
// prg_upload: streams the BASIC program in memory to the host as a PRG image.
// Ports: clk_sys/reset (async, active high); start pulse, busy, done, error, count;
//        mem_rd/mem_addr/mem_dout/mem_ack shared read port;
//        up_valid/up_data/up_ready upload byte handshake.
module prg_upload
    import vic20_pkg::*;
#(
    parameter logic [15:0] PTR_START = BASIC_PTR_START,
    parameter logic [15:0] PTR_END   = BASIC_PTR_END
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        up_valid,
    output logic [7:0]  up_data,
    input  logic        up_ready,
    output logic        done,
    output logic        error,
    output logic [15:0] count
);

    prg_up_state_t state_q, state_d;
    logic          rd_q, rd_d, valid_q, valid_d, err_q, err_d, ack;
    logic [7:0]    data_q, data_d;
    logic [15:0]   addr_q, addr_d, count_q, count_d, sa_q, sa_d, ea_q, ea_d, cur_q, cur_d, rd_addr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            sa_q    <= '0;
            ea_q    <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            count_q <= count_d;
            sa_q    <= sa_d;
            ea_q    <= ea_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        count_d = count_q;
        sa_d    = sa_q;
        ea_d    = ea_q;
        cur_d   = cur_q;
        // an ack only counts while a request is outstanding
        ack     = rd_q && mem_ack;
        rd_addr = state_q == RD_SH ? PTR_START + 16'd1 :
                  state_q == RD_EL ? PTR_END :
                  state_q == RD_EH ? PTR_END + 16'd1 :
                  state_q == FETCH ? cur_q : PTR_START;
        // every read state raises the request when idle, so a low cycle always separates reads
        if (state_q inside {RD_SL, RD_SH, RD_EL, RD_EH, FETCH}) begin
            if (!rd_q) begin
                rd_d   = 1'b1;
                addr_d = rd_addr;
            end else if (mem_ack) begin
                rd_d = 1'b0;
            end
        end
        case (state_q)
            IDLE: if (start) begin
                state_d = RD_SL;
                rd_d    = 1'b1;
                addr_d  = PTR_START;
                err_d   = 1'b0;
                count_d = '0;
            end
            RD_SL: if (ack) begin
                sa_d[7:0] = mem_dout;
                state_d   = RD_SH;
            end
            RD_SH: if (ack) begin
                sa_d[15:8] = mem_dout;
                state_d    = RD_EL;
            end
            RD_EL: if (ack) begin
                ea_d[7:0] = mem_dout;
                state_d   = RD_EH;
            end
            RD_EH: if (ack) begin
                ea_d[15:8] = mem_dout;
                state_d    = CHECK;
            end
            CHECK: if (ea_q <= sa_q) begin
                err_d   = 1'b1;
                state_d = FIN;
            end else begin
                cur_d   = sa_q;
                state_d = HDR_L;
            end
            HDR_L: if (!valid_q) begin
                valid_d = 1'b1;
                data_d  = sa_q[7:0];
            end else if (up_ready) begin
                valid_d = 1'b0;
                state_d = HDR_H;
            end
            HDR_H: if (!valid_q) begin
                valid_d = 1'b1;
                data_d  = sa_q[15:8];
            end else if (up_ready) begin
                valid_d = 1'b0;
                state_d = FETCH;
            end
            FETCH: if (ack) begin
                data_d  = mem_dout;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: if (up_ready) begin
                valid_d = 1'b0;
                count_d = count_q + 16'd1;
                cur_d   = cur_q + 16'd1;
                // ea > cur always holds, so cur+1 reaches ea before it could wrap
                state_d = cur_q + 16'd1 == ea_q ? FIN : FETCH;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = state_q != IDLE;
        done     = state_q == FIN;
        mem_rd   = rd_q;
        mem_addr = addr_q;
        up_valid = valid_q;
        up_data  = data_q;
        error    = err_q;
        count    = count_q;
    end

endmodule

// File: doc/prg_upload.md
# prg_upload

Streams the BASIC program in VIC-20 memory back to the host as a standard PRG image: a 2-byte little-endian load address followed by program bytes. It is the reverse of the PRG download path. It reads the BASIC start and end pointers from zero page, fetches each byte through the shared memory port, and hands bytes to the SPI upload side of the IO controller. It sits in the top level beside the download logic and shares the SDRAM port while the CPU clock enable is gated off.

## Interface
- PTR_START, 16'h002B: zero-page address of the BASIC start pointer (little-endian, 2 bytes).
- PTR_END, 16'h002D: zero-page address of the BASIC end pointer (little-endian, 2 bytes).
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins an upload; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until the done pulse, inclusive.
- mem_rd  out  1  level read request; held until mem_ack.
- mem_addr  out  16  read address; stable while mem_rd is high.
- mem_dout  in  8  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle strobe completing a read.
- up_valid  out  1  upload byte available.
- up_data  out  8  upload byte; stable while up_valid is high.
- up_ready  in  1  host accepts the byte when up_valid and up_ready are both high on a clock edge.
- done  out  1  one-cycle pulse at the end of an upload.
- error  out  1  set when end ≤ start; cleared by the next accepted start.
- count  out  16  program bytes sent in the current or last upload, excluding the header.

## Operation
- States: IDLE, RD_SL, RD_SH, RD_EL, RD_EH, CHECK, HDR_L, HDR_H, FETCH, SEND, FIN.
- IDLE, on start: clear count and error, then go to RD_SL.
- RD_SL/RD_SH read PTR_START and PTR_START+1 into sa[7:0] and sa[15:8].
- RD_EL/RD_EH read PTR_END and PTR_END+1 into ea.
- CHECK:
  - If ea ≤ sa (unsigned), set error and go to FIN. No bytes are sent, not even the header.
  - Otherwise set cur=sa and go to HDR_L.
- HDR_L sends sa[7:0]. HDR_H sends sa[15:8].
- FETCH reads cur. SEND presents the byte. On acceptance: count+1, cur+1. If cur+1 == ea go to FIN, else go back to FETCH.
- FIN: pulse done for one cycle, drop busy, return to IDLE.
- cur never wraps past 16'hFFFF, because ea > cur always holds. An end value of 16'hFFFF sends up to and including address 16'hFFFE.
- A start pulse while busy is ignored. A start in the same cycle as done is also ignored.
- Reset mid-operation aborts immediately. No done pulse is produced and the host sees a truncated stream.

## Timing
- Reset values: busy=0, mem_rd=0, mem_addr=0, up_valid=0, up_data=0, done=0, error=0, count=0. State is IDLE.
- Start accepted at edge N: busy and mem_rd rise after edge N, with mem_addr=PTR_START.
- mem_rd falls on the edge that samples mem_ack. The next request may rise on the following edge, so there is at least one low cycle between reads.
- mem_ack while mem_rd is low is ignored.
- The byte read is registered into up_data on the mem_ack edge. up_valid rises on that same edge.
- up_valid stays high with up_data unchanged until up_ready is sampled high. up_valid falls on that edge.
- up_ready may be high before up_valid. The transfer then completes on the first edge where up_valid is high.
- Each byte costs at least 3 cycles: read request, ack, handshake.
- Header bytes need no memory read. up_valid rises one cycle after entering HDR_L.
- done rises one edge after the last handshake, or one edge after CHECK on error.

## Structure
- Shared package vic20_pkg holds:
  - the state enum type prg_up_state_t;
  - localparams BASIC_PTR_START=16'h002B and BASIC_PTR_END=16'h002D, used as the parameter defaults.
- Single module, no sub-module. The memory handshake is a single state pair and does not justify its own module.

## Test plan
- Normal upload: memory 2B/2C=01,10 and 2D/2E=05,10, bytes at 1001..1004 = AA,BB,CC,DD, up_ready always high. Stream is 01,10,AA,BB,CC,DD, then count=4, done pulses once, error=0.
- Backpressure: same image, up_ready high only every 5th cycle. Identical stream, up_data never changes while up_valid is high and up_ready is low, no byte is duplicated.
- Empty or invalid program: end=start=1001 gives error=1, done pulses, zero up_valid beats. end=1000, start=1001 gives the same result.
- Variable memory latency: mem_ack 1 to 12 cycles after mem_rd, plus a spurious mem_ack while mem_rd is low. Stream is correct and the spurious ack is ignored.
- Top-of-memory boundary: start=FFFD, end=FFFF. Stream is FD,FF, then bytes at FFFD and FFFE; count=2.
- Reset and retrigger: reset asserted during SEND makes all outputs reset values in the same cycle. A start during busy is ignored. A new start after reset produces the full, correct stream.
